// File: rtl/fifo_wctl.sv
// Write-side control for an asynchronous FIFO: binary/Gray write pointer,
// registered full / almost_full / level, and a sticky overflow flag.
module fifo_wctl #(
  parameter int ADDRWIDTH    = 8,
  parameter int AFULL_THRESH = 2**ADDRWIDTH - 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 ovf_clr,
  input  logic [ADDRWIDTH:0]   rptr_gray_sync,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic                 wr_ram,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDRWIDTH:0]   wr_level,
  output logic                 overflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);
  // Full means the write pointer equals the read pointer with the two Gray MSBs inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic          full_next;

  assign wr_ram = wr_en & ~full;
  assign waddr  = wbin[ADDRWIDTH-1:0];

  always_comb begin
    wbin_next  = wbin + PW'(wr_ram);
    gray_next  = bin2gray(wbin_next);
    rbin       = gray2bin(rptr_gray_sync);
    level_next = wbin_next - rbin;
    full_next  = (gray_next == (rptr_gray_sync ^ FULL_MASK));
  end

  // Register stage: every status output is derived from the post-write pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= gray_next;
      full        <= full_next;
      almost_full <= (level_next >= AFULL_LVL);
      wr_level    <= level_next;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_wctl.md
FIFO_WCTL -- requirements
Module: fifo_wctl

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 8, meaning the FIFO RAM address width (depth = 2^ADDRWIDTH; pointer width = ADDRWIDTH+1).
REQ-002 SHALL have parameter AFULL_THRESH, default 2^ADDRWIDTH-4, meaning the almost_full level threshold.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  write-domain clock; all state changes on posedge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 wr_en  in  1  write request from the producer.
REQ-007 ovf_clr  in  1  clears the sticky overflow flag.
REQ-008 rptr_gray_sync  in  ADDRWIDTH+1  read pointer (Gray), already synchronized into this domain by the 2-flop synchronizer.
REQ-009 wptr_gray  out  ADDRWIDTH+1  registered write pointer (Gray), fed to the read-domain synchronizer.
REQ-010 waddr  out  ADDRWIDTH  RAM write address.
REQ-011 wr_ram  out  1  RAM write strobe.
REQ-012 full  out  1  FIFO full, registered.
REQ-013 almost_full  out  1  level >= AFULL_THRESH, registered.
REQ-014 wr_level  out  ADDRWIDTH+1  write-side occupancy estimate, registered.
REQ-015 overflow  out  1  sticky: a write was attempted while full.

Function
REQ-016 SHALL hold the binary write pointer wbin (ADDRWIDTH+1 bits) and the Gray pointer wptr_gray in registers.
REQ-017 wr_ram SHALL be combinational: wr_en & ~full.
REQ-018 waddr SHALL equal wbin[ADDRWIDTH-1:0] from the register, with no added latency.
REQ-019 wbin_next SHALL be wbin+1 when wr_ram, else wbin; the increment wraps modulo 2^(ADDRWIDTH+1).
REQ-020 wptr_gray SHALL load wbin_next ^ (wbin_next >> 1) on every edge; only one bit changes per increment.
REQ-021 full SHALL load (gray(wbin_next) == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}), so it updates on the same edge as the pointer.
REQ-022 rbin SHALL be the combinational Gray-to-binary conversion of rptr_gray_sync.
REQ-023 wr_level SHALL load (wbin_next - rbin) mod 2^(ADDRWIDTH+1), with range 0..2^ADDRWIDTH.
REQ-024 almost_full SHALL load (wbin_next - rbin) >= AFULL_THRESH.
REQ-025 A write accepted on the edge that fills the FIFO SHALL cause full=1 starting in the next cycle; no extra write can slip through.
REQ-026 When full and wr_en=1: wr_ram=0, wbin is unchanged, and overflow is set on that edge.
REQ-027 A change in rptr_gray_sync (read-side drain) SHALL be reflected in full, almost_full and wr_level one edge later; full deasserts pessimistically, never early.
REQ-028 If a write and a read-pointer advance occur in the same cycle, the registered outputs SHALL use both (wbin_next and the new rbin).
REQ-029 overflow SHALL clear on ovf_clr=1 unless set in the same cycle; set has priority over clear.
REQ-030 Combinational inputs SHALL never drive wptr_gray; it is register-only, so it is glitch-free for CDC.

Reset
REQ-031 On reset=1 at posedge: wbin=0, wptr_gray=0, full=0, almost_full=0, wr_level=0, overflow=0; waddr=0 and wr_ram=wr_en follow from that state.
REQ-032 Reset SHALL take priority over wr_en and ovf_clr, and SHALL abort any in-progress fill immediately.
REQ-033 The read side and its synchronizer SHALL be reset together; this block does not check rptr_gray_sync during reset.

Verification (ADDRWIDTH=3, AFULL_THRESH=6)
REQ-034 Reset held 2 cycles with wr_en=1 -> all registered outputs 0; wptr_gray=4'b0000; wr_ram=1 after release.
REQ-035 rptr_gray_sync=0, wr_en=1 for 8 cycles -> waddr steps 0..7; almost_full=1 after the 6th edge; full=1 after the 8th edge; wptr_gray=4'b1100; wr_level=8; waddr=0.
REQ-036 While full, wr_en=1 for 1 cycle -> wr_ram=0; wptr_gray stays 4'b1100; overflow=1 and persists; ovf_clr=1 for one cycle -> overflow=0 next cycle.
REQ-037 While full, rptr_gray_sync set to 4'b0001 -> full=0 and wr_level=7 after one edge; almost_full stays 1.
REQ-038 Wrap: wbin=8, rptr_gray_sync=4'b1100 (empty, level 0), then 8 writes -> wbin wraps to 0; wptr_gray=4'b0000; full=1; wr_level=8.
REQ-039 Reset asserted mid-fill at level 5 -> next cycle wbin=0, wr_level=0, full=0, with no spurious wr_ram during reset beyond wr_en & ~full.
